// File: rtl/norm_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | norm_arbiter_pkg : shared constants and width helpers             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package norm_arbiter_pkg;

  localparam int unsigned C_DEF_N_REQ      = 4;
  localparam int unsigned C_DEF_MANT_W     = 51;
  localparam int unsigned C_DEF_LEADONE_W  = 6;
  localparam int unsigned C_DEF_EXP_W      = 11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A single lane still needs a one-bit id field.
  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/norm_arbiter_lzc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | norm_arbiter_lzc : variable-width leading-zero counter            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module norm_arbiter_lzc #(
  parameter int unsigned WIDTH     = 51,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic [WIDTH-1:0]     i_data,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_zero
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_cnt  = '0;
    o_zero = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_data[i]) begin
        o_cnt  = CNT_WIDTH'(int'(WIDTH) - 1 - i);
        o_zero = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/norm_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | norm_arbiter : round-robin lanes feeding one 2-stage normalizer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module norm_arbiter
  import norm_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ           = C_DEF_N_REQ,
  parameter int unsigned C_WIDTH         = C_DEF_MANT_W,
  parameter int unsigned C_LEADONE_WIDTH = C_DEF_LEADONE_W,
  parameter int unsigned C_EXP_WIDTH     = C_DEF_EXP_W
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic [N_REQ-1:0]               req_valid_I,
  output logic [N_REQ-1:0]               req_ready_O,
  input  logic [N_REQ*C_WIDTH-1:0]       req_mant_I,
  input  logic [N_REQ*C_EXP_WIDTH-1:0]   req_exp_I,
  output logic                           res_valid_O,
  input  logic                           res_ready_I,
  output logic [C_WIDTH-1:0]             res_mant_O,
  output logic [C_EXP_WIDTH-1:0]         res_exp_O,
  output logic [id_width(N_REQ)-1:0]     res_id_O,
  output logic                           res_zero_O,
  output logic                           res_uf_O
);

  localparam int unsigned C_ID_W = id_width(N_REQ);

  logic [C_ID_W-1:0]          r_ptr;
  logic [C_ID_W-1:0]          w_grant_id;
  logic                       w_grant_found;
  logic                       w_s2_free;
  logic                       w_s1_adv;
  logic                       w_s1_free;
  logic                       w_accept;

  logic                       r_s1_valid;
  logic [C_WIDTH-1:0]         r_s1_mant;
  logic [C_EXP_WIDTH-1:0]     r_s1_exp;
  logic [C_ID_W-1:0]          r_s1_id;

  logic                       r_s2_valid;
  logic [C_WIDTH-1:0]         r_s2_mant;
  logic [C_EXP_WIDTH-1:0]     r_s2_exp;
  logic [C_ID_W-1:0]          r_s2_id;
  logic                       r_s2_zero;
  logic                       r_s2_uf;

  logic [C_LEADONE_WIDTH-1:0] w_lz;
  logic                       w_mant_zero;
  logic [C_WIDTH-1:0]         w_norm_mant;
  logic [C_EXP_WIDTH-1:0]     w_norm_exp;
  logic                       w_norm_zero;
  logic                       w_norm_uf;

  // First valid lane at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!w_grant_found && req_valid_I[(int'(r_ptr) + k) % int'(N_REQ)]) begin
        w_grant_found = 1'b1;
        w_grant_id    = C_ID_W'((int'(r_ptr) + k) % int'(N_REQ));
      end
    end
  end

  assign w_s2_free = !r_s2_valid || res_ready_I;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_accept  = w_grant_found && w_s1_free && Rst_RBI;

  always_comb begin
    req_ready_O = '0;
    if (w_accept) req_ready_O[w_grant_id] = 1'b1;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s1_id    <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_mant  <= req_mant_I[int'(w_grant_id)*int'(C_WIDTH) +: C_WIDTH];
        r_s1_exp   <= req_exp_I[int'(w_grant_id)*int'(C_EXP_WIDTH) +: C_EXP_WIDTH];
        r_s1_id    <= w_grant_id;
        r_ptr      <= (w_grant_id == C_ID_W'(N_REQ - 1)) ? '0 : w_grant_id + C_ID_W'(1);
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  norm_arbiter_lzc #(
    .WIDTH     (C_WIDTH),
    .CNT_WIDTH (C_LEADONE_WIDTH)
  ) u_lzc (
    .i_data (r_s1_mant),
    .o_cnt  (w_lz),
    .o_zero (w_mant_zero)
  );

  // Shift stops at exponent zero, flagging underflow instead of going negative.
  always_comb begin
    w_norm_mant = '0;
    w_norm_exp  = '0;
    w_norm_zero = 1'b0;
    w_norm_uf   = 1'b0;
    if (w_mant_zero) begin
      w_norm_zero = 1'b1;
    end else if (32'(w_lz) < 32'(r_s1_exp)) begin
      w_norm_mant = r_s1_mant << w_lz;
      w_norm_exp  = r_s1_exp - C_EXP_WIDTH'(w_lz);
    end else begin
      w_norm_mant = r_s1_mant << r_s1_exp;
      w_norm_uf   = 1'b1;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_s2_valid <= 1'b0;
      r_s2_mant  <= '0;
      r_s2_exp   <= '0;
      r_s2_id    <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_uf    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_mant  <= w_norm_mant;
      r_s2_exp   <= w_norm_exp;
      r_s2_id    <= r_s1_id;
      r_s2_zero  <= w_norm_zero;
      r_s2_uf    <= w_norm_uf;
    end else if (res_ready_I) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign res_valid_O = r_s2_valid;
  assign res_mant_O  = r_s2_mant;
  assign res_exp_O   = r_s2_exp;
  assign res_id_O    = r_s2_id;
  assign res_zero_O  = r_s2_zero;
  assign res_uf_O    = r_s2_uf;

endmodule
`default_nettype wire

// File: tb/tb_norm_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_norm_arbiter : reference-model bench for norm_arbiter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_norm_arbiter;

  localparam int NL = 4;
  localparam int MW = 51;
  localparam int EW = 11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NL-1:0]   req_valid;
  logic [NL-1:0]   req_ready;
  logic [NL*MW-1:0] mant_bus;
  logic [NL*EW-1:0] exp_bus;
  logic            res_valid;
  logic            res_ready;
  logic [MW-1:0]   res_mant;
  logic [EW-1:0]   res_exp;
  logic [1:0]      res_id;
  logic            res_zero;
  logic            res_uf;

  logic [MW-1:0]   d_mant [NL];
  logic [EW-1:0]   d_exp  [NL];

  always #5 clk = ~clk;

  always_comb begin
    mant_bus = '0;
    exp_bus  = '0;
    for (int l = 0; l < NL; l++) begin
      mant_bus[l*MW +: MW] = d_mant[l];
      exp_bus[l*EW +: EW]  = d_exp[l];
    end
  end

  norm_arbiter dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .req_valid_I (req_valid),
    .req_ready_O (req_ready),
    .req_mant_I  (mant_bus),
    .req_exp_I   (exp_bus),
    .res_valid_O (res_valid),
    .res_ready_I (res_ready),
    .res_mant_O  (res_mant),
    .res_exp_O   (res_exp),
    .res_id_O    (res_id),
    .res_zero_O  (res_zero),
    .res_uf_O    (res_uf)
  );

  typedef struct {
    logic [MW-1:0] m;
    logic [EW-1:0] e;
    int            id;
    int            acc;
  } item_t;

  item_t         q[$];
  int            ids_log[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            edge_cnt = 0;
  int            neg_cnt = 0;
  int            ptr = 0;
  int            seq = 0;
  int            acc_total = 0;
  int            out_total = 0;
  int            first_acc_neg = -1;
  int            first_out_neg = -1;
  logic [NL-1:0] last_fire = '0;
  bit            auto_adv = 1'b0;
  bit            prev_hold = 1'b0;
  logic [MW-1:0] pm;
  logic [EW-1:0] pe;
  logic [1:0]    pid;
  logic          pz, pu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Normalize by shifting one place at a time until the MSB is set or the exponent runs out.
  function automatic void model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                output logic [MW-1:0] om, output logic [EW-1:0] oe,
                                output bit z, output bit u);
    om = m; oe = e; z = 1'b0; u = 1'b0;
    if (m == '0) begin
      oe = '0;
      z  = 1'b1;
    end else begin
      while (!om[MW-1] && oe != '0) begin
        om = om << 1;
        oe = oe - 1'b1;
      end
      u = (oe == '0);
    end
  endfunction

  task automatic gen(input int l);
    seq++;
    d_mant[l] = (seq % 9 == 0) ? '0 : ((51'h5 << ((seq * 7) % 49)) | 51'(seq));
    d_exp[l]  = 11'((seq * 13) % 70);
  endtask

  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    #2;
    if (auto_adv) begin
      for (int l = 0; l < NL; l++) if (last_fire[l]) gen(l);
    end
  end

  always @(negedge clk) begin : monitor
    logic [NL-1:0] exp_rdy;
    int            lane;
    logic [MW-1:0] xm;
    logic [EW-1:0] xe;
    bit            xz, xu, xv;
    item_t         it;
    neg_cnt++;
    if (!rst_n) begin
      q.delete();
      ptr       = 0;
      last_fire = '0;
      prev_hold = 1'b0;
      acc_total = 0;
      out_total = 0;
    end else begin
      exp_rdy = '0;
      lane    = -1;
      for (int k = 0; k < NL; k++)
        if (lane < 0 && req_valid[(ptr + k) % NL]) lane = (ptr + k) % NL;
      if (lane >= 0 && (q.size() < 2 || res_ready)) exp_rdy[lane] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      xv = (q.size() > 0) && (edge_cnt - q[0].acc >= 1);
      chk("res_valid", 64'(res_valid), 64'(xv));
      if (prev_hold) begin
        chk("hold_mant", 64'(res_mant), 64'(pm));
        chk("hold_exp",  64'(res_exp),  64'(pe));
        chk("hold_id",   64'(res_id),   64'(pid));
        chk("hold_flags", 64'({res_zero, res_uf}), 64'({pz, pu}));
      end
      if (xv && res_valid) begin
        model(q[0].m, q[0].e, xm, xe, xz, xu);
        chk("res_mant", 64'(res_mant), 64'(xm));
        chk("res_exp",  64'(res_exp),  64'(xe));
        chk("res_id",   64'(res_id),   64'(q[0].id));
        chk("res_zero", 64'(res_zero), 64'(xz));
        chk("res_uf",   64'(res_uf),   64'(xu));
      end
      prev_hold = res_valid && !res_ready;
      pm = res_mant; pe = res_exp; pid = res_id; pz = res_zero; pu = res_uf;
      if (res_valid && res_ready) begin
        out_total++;
        if (first_out_neg < 0) first_out_neg = neg_cnt;
        ids_log.push_back(int'(res_id));
      end
      if (xv && res_ready) void'(q.pop_front());
      if (|(req_valid & req_ready)) begin
        acc_total++;
        if (first_acc_neg < 0) first_acc_neg = neg_cnt;
      end
      if (|exp_rdy) begin
        it.m   = d_mant[lane];
        it.e   = d_exp[lane];
        it.id  = lane;
        it.acc = edge_cnt + 1;
        q.push_back(it);
        ptr = (lane + 1) % NL;
      end
      last_fire = exp_rdy;
    end
  end

  task automatic send_one(input int lane, input logic [MW-1:0] m, input logic [EW-1:0] e,
                          input logic [MW-1:0] xm, input logic [EW-1:0] xe,
                          input bit xz, input bit xu, input string nm);
    bit got;
    @(posedge clk); #2;
    d_mant[lane] = m;
    d_exp[lane]  = e;
    req_valid[lane] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req_ready[lane]) got = 1'b1;
    end
    if (!got) chk({nm, "_accept_timeout"}, 64'(0), 64'(1));
    @(posedge clk); #2;
    req_valid[lane] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    if (!got) chk({nm, "_result_timeout"}, 64'(0), 64'(1));
    chk({nm, "_id"},   64'(res_id),   64'(lane));
    chk({nm, "_mant"}, 64'(res_mant), 64'(xm));
    chk({nm, "_exp"},  64'(res_exp),  64'(xe));
    chk({nm, "_zero"}, 64'(res_zero), 64'(xz));
    chk({nm, "_uf"},   64'(res_uf),   64'(xu));
  endtask

  initial begin : main
    int a0;
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    for (int l = 0; l < NL; l++) begin
      d_mant[l] = '0;
      d_exp[l]  = '0;
    end
    #12;
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_mant",  64'(res_mant),  64'(0));
    chk("rst_res_exp",   64'(res_exp),   64'(0));
    chk("rst_res_id",    64'(res_id),    64'(0));
    chk("rst_flags",     64'({res_zero, res_uf}), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;

    // all lanes streaming, no backpressure
    for (int l = 0; l < NL; l++) gen(l);
    req_valid = '1;
    auto_adv  = 1'b1;
    repeat (20) @(posedge clk);
    if (ids_log.size() >= 5) begin
      chk("rr_id0", 64'(ids_log[0]), 64'(0));
      chk("rr_id1", 64'(ids_log[1]), 64'(1));
      chk("rr_id2", 64'(ids_log[2]), 64'(2));
      chk("rr_id3", 64'(ids_log[3]), 64'(3));
      chk("rr_id4", 64'(ids_log[4]), 64'(0));
    end else begin
      chk("rr_result_count", 64'(ids_log.size()), 64'(5));
    end
    chk("first_latency", 64'(first_out_neg - first_acc_neg), 64'(2));

    // backpressure for five cycles while lanes keep requesting
    #2;
    res_ready = 1'b0;
    a0 = acc_total;
    repeat (5) @(negedge clk);
    chk("stall_held", 64'(acc_total - out_total), 64'(2));
    chk("stall_no_accept", 64'(acc_total - a0), 64'(0));
    @(posedge clk); #2;
    res_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    req_valid = '0;
    auto_adv  = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_empty", 64'(acc_total - out_total), 64'(0));

    send_one(2, 51'h1,   11'd100, 51'h4_0000_0000_0000, 11'd50, 1'b0, 1'b0, "lane2_norm");
    send_one(1, 51'h0,   11'd77,  51'h0,                11'd0,  1'b1, 1'b0, "lane1_zero");
    send_one(3, 51'h400, 11'd5,   51'h8000,             11'd0,  1'b0, 1'b1, "lane3_uf");

    // reset in the middle of a stream
    @(posedge clk); #2;
    for (int l = 0; l < NL; l++) gen(l);
    req_valid = '1;
    auto_adv  = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    chk("midrst_res_mant",  64'(res_mant),  64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_after_rst", 64'(req_ready), 64'(4'b0001));
    repeat (10) @(posedge clk);
    #2;
    req_valid = '0;
    auto_adv  = 1'b0;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/norm_arbiter.md
NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesting lanes sharing one normalizer.
REQ-002 SHALL have parameter C_WIDTH, default 51, mantissa width.
REQ-003 SHALL have parameter C_LEADONE_WIDTH, default 6, leading-zero count width.
REQ-004 SHALL have parameter C_EXP_WIDTH, default 11, exponent width.
REQ-005 SHALL have port Clk_CI, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port Rst_RBI, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid_I, input, N_REQ, per-lane operand valid.
REQ-008 SHALL have port req_ready_O, output, N_REQ, per-lane accept.
REQ-009 SHALL have port req_mant_I, input, N_REQ*C_WIDTH, lane i at bits [i*C_WIDTH +: C_WIDTH].
REQ-010 SHALL have port req_exp_I, input, N_REQ*C_EXP_WIDTH, unsigned biased exponent per lane.
REQ-011 SHALL have port res_valid_O, output, 1, result valid.
REQ-012 SHALL have port res_ready_I, input, 1, downstream accept.
REQ-013 SHALL have port res_mant_O, output, C_WIDTH, normalized mantissa.
REQ-014 SHALL have port res_exp_O, output, C_EXP_WIDTH, adjusted exponent.
REQ-015 SHALL have port res_id_O, output, clog2(N_REQ), originating lane.
REQ-016 SHALL have ports res_zero_O and res_uf_O, output, 1 each, zero-mantissa and underflow flags.

Function
REQ-017 SHALL transfer on a channel only when valid and ready are both high in the same cycle.
REQ-018 SHALL grant at most one lane per cycle, round-robin: search starts at lane ptr, ptr = granted lane + 1 (mod N_REQ) after each transfer; ptr unchanged when no transfer.
REQ-019 SHALL assert req_ready_O only for the granted lane, and only when stage 1 is empty or advancing in the same cycle.
REQ-020 SHALL keep req_ready_O independent of the granted lane's own req_valid_I combinational path except through the arbiter (no ready-from-ready loops).
REQ-021 Stage 1 SHALL register mantissa, exponent and lane id of the accepted operand.
REQ-022 Stage 2 SHALL compute lz = leading zero count of the stage-1 mantissa (MSB = bit C_WIDTH-1) and register the result.
REQ-023 If mantissa is zero: res_mant_O = 0, res_exp_O = 0, res_zero_O = 1, res_uf_O = 0.
REQ-024 Else if lz < exp: res_mant_O = mant << lz, res_exp_O = exp - lz, flags 0.
REQ-025 Else (lz >= exp): res_mant_O = mant << exp, res_exp_O = 0, res_uf_O = 1.
REQ-026 Latency SHALL be exactly 2 cycles from request transfer to res_valid_O with no backpressure; throughput one result per cycle.
REQ-027 While res_valid_O=1 and res_ready_I=0, all result outputs SHALL hold stable and stage 1 SHALL hold; new requests SHALL be refused once stage 1 is full.
REQ-028 Simultaneous result consume and new request SHALL both complete in the same cycle (full pipelining, no bubble).
REQ-029 Results SHALL leave in acceptance order; no operand SHALL be dropped or duplicated.

Reset
REQ-030 On Rst_RBI low, both stage valid bits SHALL clear immediately and ptr SHALL become 0.
REQ-031 During and after reset: res_valid_O=0, req_ready_O=0 while in reset, res_mant_O=0, res_exp_O=0, res_id_O=0, res_zero_O=0, res_uf_O=0.
REQ-032 Reset mid-operation SHALL discard all in-flight operands; first grant after release SHALL go to lane 0 if valid.

Structure
REQ-033 clog2 helper and width constants SHALL live in the shared fpu package; no new typedefs.
REQ-034 The leading-zero count SHALL be one instance of the existing variable-width LZC module (C_WIDTH, C_LEADONE_WIDTH); no other sub-modules.

Verification
REQ-035 All four lanes valid continuously, res_ready_I=1 -> ids 0,1,2,3,0,... one per cycle, first result 2 cycles after first accept.
REQ-036 Lane 2 mant=0x0_0000_0000_0001 (bit 0), exp=100 -> res_mant bit 50 set, res_exp=50, flags 0.
REQ-037 Lane 1 mant=0, exp=77 -> res_mant=0, res_exp=0, res_zero=1.
REQ-038 Lane 3 mant bit 10 only, exp=5 -> res_mant bit 15 set, res_exp=0, res_uf=1.
REQ-039 res_ready_I low for 5 cycles with lanes streaming -> outputs stable, exactly two operands held, then ordered drain with no loss.
REQ-040 Assert Rst_RBI mid-stream -> res_valid_O drops same cycle (asynchronously); after release lane 0 granted first.
